tag_allocator_icache: RTL and testbench

- Write/allocation side of the icache tag path.
- Owns the per-set tag and valid storage. Serves set reads (tag_of_set_o and way_valid_o) to the downstream tag checker.
- Accepts refill requests after a miss, picks a victim way, and writes the tag and valid bit.
- Runs a whole-cache invalidate (flush) sequence, clearing one set per cycle.

---
 rtl/icache_pkg.sv | 25 ++
 rtl/victim_sel_icache.sv | 30 +++
 rtl/tag_allocator_icache.sv | 127 ++++++++++++
 tb/tb_tag_allocator_icache.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared constants, FSM encoding and helpers for the icache tag allocator.
package icache_pkg;

    localparam int TAG_WIDTH = 7;
    localparam int NUM_WAY   = 2;
    localparam int NUM_SET   = 32;
    localparam int WAY_DEPTH = $clog2(NUM_WAY);
    localparam int SET_DEPTH = $clog2(NUM_SET);

    typedef enum logic {
        FLUSH_IDLE = 1'b0,
        FLUSH_RUN  = 1'b1
    } flush_state_e;

    // Converts a one-hot way vector into its binary way index.
    function automatic logic [WAY_DEPTH-1:0] one2bin(input logic [NUM_WAY-1:0] onehot);
        logic [WAY_DEPTH-1:0] bin;
        bin = '0;
        for (int i = 0; i < NUM_WAY; i++) begin
            if (onehot[i]) bin = bin | WAY_DEPTH'(i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/victim_sel_icache.sv
// Victim way selection: lowest invalid way, else the set's round-robin pointer.
module victim_sel_icache
    import icache_pkg::*;
(
    input  logic [NUM_WAY-1:0]   i_valid,
    input  logic [WAY_DEPTH-1:0] i_ptr,
    output logic [WAY_DEPTH-1:0] o_victim,
    output logic                 o_from_ptr
);

    logic [NUM_WAY-1:0] w_onehot;
    logic               w_found;

    // Isolate the lowest-index invalid way as a one-hot vector.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        w_onehot = '0;
        w_found  = 1'b0;
        for (int i = 0; i < NUM_WAY; i++) begin
            if (!i_valid[i] && !w_found) begin
                w_onehot[i] = 1'b1;
                w_found     = 1'b1;
            end
        end
    end

    assign o_from_ptr = &i_valid;
    assign o_victim   = o_from_ptr ? i_ptr : one2bin(w_onehot);

endmodule

// File: rtl/tag_allocator_icache.sv
// Icache tag/valid storage with refill allocation and whole-cache flush.
// Optional macro ICACHE_REFILL_BYPASS_EN: same-cycle refill/flush writes are
// forwarded to the read outputs of the same set.
module tag_allocator_icache
    import icache_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           r_req_valid_i,
    input  logic [SET_DEPTH-1:0]           r_req_setid_i,
    output logic [NUM_WAY*TAG_WIDTH-1:0]   tag_of_set_o,
    output logic [NUM_WAY-1:0]             way_valid_o,
    input  logic                           refill_valid_i,
    output logic                           refill_ready_o,
    input  logic [SET_DEPTH-1:0]           refill_setid_i,
    input  logic [TAG_WIDTH-1:0]           refill_tag_i,
    output logic [WAY_DEPTH-1:0]           refill_wayid_o,
    input  logic                           invalidate_i,
    output logic                           flush_busy_o,
    output logic                           flush_done_o
);

    flush_state_e                r_state;
    flush_state_e                w_state_next;
    logic [SET_DEPTH-1:0]        r_cnt;
    logic                        r_flush_done;

    logic [TAG_WIDTH-1:0]        r_tag   [NUM_SET][NUM_WAY];
    logic [NUM_WAY-1:0]          r_valid [NUM_SET];
    logic [WAY_DEPTH-1:0]        r_ptr   [NUM_SET];

    logic [NUM_WAY*TAG_WIDTH-1:0] r_tag_out;
    logic [NUM_WAY-1:0]           r_valid_out;

    logic [WAY_DEPTH-1:0]        w_victim;
    logic                        w_from_ptr;
    logic                        w_fire;
    logic                        w_flush_last;
    logic [WAY_DEPTH-1:0]        w_ptr_next;

    victim_sel_icache u_victim_sel (
        .i_valid    (r_valid[refill_setid_i]),
        .i_ptr      (r_ptr[refill_setid_i]),
        .o_victim   (w_victim),
        .o_from_ptr (w_from_ptr)
    );

    assign refill_ready_o = (r_state == FLUSH_IDLE);
    assign refill_wayid_o = w_victim;
    assign w_fire         = refill_valid_i && refill_ready_o;
    assign w_flush_last   = (r_cnt == SET_DEPTH'(NUM_SET - 1));
    assign w_ptr_next     = (r_ptr[refill_setid_i] == WAY_DEPTH'(NUM_WAY - 1))
                          ? '0 : r_ptr[refill_setid_i] + 1'b1;

    assign flush_busy_o   = (r_state == FLUSH_RUN);
    assign flush_done_o   = r_flush_done;
    assign tag_of_set_o   = r_tag_out;
    assign way_valid_o    = r_valid_out;

    // Flush FSM next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FLUSH_IDLE: if (invalidate_i) w_state_next = FLUSH_RUN;
            FLUSH_RUN:  if (w_flush_last) w_state_next = FLUSH_IDLE;
            default:    w_state_next = FLUSH_IDLE;
        endcase
    end

    // Flush FSM state, set counter and completion pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            r_state      <= FLUSH_IDLE;
            r_cnt        <= '0;
            r_flush_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_flush_done <= (r_state == FLUSH_RUN) && (w_state_next == FLUSH_IDLE);
            if (r_state == FLUSH_IDLE) r_cnt <= '0;
            else                       r_cnt <= r_cnt + 1'b1;
        end
    end

    // Tag/valid/pointer storage: refill writes and per-set flush clears.
    always_ff @(posedge clk) begin
        // NOTE: this storage is register-based and is fully cleared by reset,
        // so it cannot be mapped onto a RAM macro.
        if (rst) begin
            for (int s = 0; s < NUM_SET; s++) begin
                r_valid[s] <= '0;
                r_ptr[s]   <= '0;
                for (int w = 0; w < NUM_WAY; w++) r_tag[s][w] <= '0;
            end
        end else if (r_state == FLUSH_RUN) begin
            r_valid[r_cnt] <= '0;
            r_ptr[r_cnt]   <= '0;
        end else if (w_fire) begin
            r_tag[refill_setid_i][w_victim]   <= refill_tag_i;
            r_valid[refill_setid_i][w_victim] <= 1'b1;
            if (w_from_ptr) r_ptr[refill_setid_i] <= w_ptr_next;
        end
    end

    // Registered set read, holding its value while no read is requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_out   <= '0;
            r_valid_out <= '0;
        end else if (r_req_valid_i) begin
            for (int w = 0; w < NUM_WAY; w++) begin
                r_tag_out[TAG_WIDTH*(w+1)-1 -: TAG_WIDTH] <= r_tag[r_req_setid_i][w];
            end
            r_valid_out <= r_valid[r_req_setid_i];
`ifdef ICACHE_REFILL_BYPASS_EN
            if (w_fire && (refill_setid_i == r_req_setid_i)) begin
                r_tag_out[TAG_WIDTH*w_victim +: TAG_WIDTH] <= refill_tag_i;
                r_valid_out[w_victim]                      <= 1'b1;
            end
            if ((r_state == FLUSH_RUN) && (r_cnt == r_req_setid_i)) begin
                r_valid_out <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_tag_allocator_icache.sv
// Directed self-checking bench for tag_allocator_icache.
module tb_tag_allocator_icache;

    logic        clk;
    logic        rst;
    logic        r_req_valid_i;
    logic [4:0]  r_req_setid_i;
    logic [13:0] tag_of_set_o;
    logic [1:0]  way_valid_o;
    logic        refill_valid_i;
    logic        refill_ready_o;
    logic [4:0]  refill_setid_i;
    logic [6:0]  refill_tag_i;
    logic [0:0]  refill_wayid_o;
    logic        invalidate_i;
    logic        flush_busy_o;
    logic        flush_done_o;

    int checks = 0;
    int errors = 0;
    int n;
    logic saw_done;

    tag_allocator_icache dut (
        .clk            (clk),
        .rst            (rst),
        .r_req_valid_i  (r_req_valid_i),
        .r_req_setid_i  (r_req_setid_i),
        .tag_of_set_o   (tag_of_set_o),
        .way_valid_o    (way_valid_o),
        .refill_valid_i (refill_valid_i),
        .refill_ready_o (refill_ready_o),
        .refill_setid_i (refill_setid_i),
        .refill_tag_i   (refill_tag_i),
        .refill_wayid_o (refill_wayid_o),
        .invalidate_i   (invalidate_i),
        .flush_busy_o   (flush_busy_o),
        .flush_done_o   (flush_done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refill(input logic [4:0] set, input logic [6:0] tag,
                          input logic [0:0] exp_way, input string name);
        refill_valid_i = 1'b1;
        refill_setid_i = set;
        refill_tag_i   = tag;
        #1;
        check(name, 32'(refill_wayid_o), 32'(exp_way));
        tick();
        refill_valid_i = 1'b0;
    endtask

    task automatic read(input logic [4:0] set);
        r_req_valid_i = 1'b1;
        r_req_setid_i = set;
        tick();
        r_req_valid_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1; r_req_valid_i = 1'b0; r_req_setid_i = '0;
        refill_valid_i = 1'b0; refill_setid_i = '0; refill_tag_i = '0;
        invalidate_i = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_valid", 32'(way_valid_o), 32'h0);
        check("rst_tag",   32'(tag_of_set_o), 32'h0);
        check("rst_busy",  32'(flush_busy_o), 32'h0);
        check("rst_done",  32'(flush_done_o), 32'h0);
        check("rst_ready", 32'(refill_ready_o), 32'h1);

        read(5'd3);
        check("rd3_valid", 32'(way_valid_o), 32'h0);
        check("rd3_tag",   32'(tag_of_set_o), 32'h0);
        check("rd3_ready", 32'(refill_ready_o), 32'h1);

        // Fill set 5 with invalid ways first, then round-robin
        refill(5'd5, 7'h12, 1'b0, "way_5a");
        refill(5'd5, 7'h34, 1'b1, "way_5b");
        read(5'd5);
        check("rd5_tag",   32'(tag_of_set_o), 32'({7'h34, 7'h12}));
        check("rd5_valid", 32'(way_valid_o), 32'h3);
        refill(5'd5, 7'h56, 1'b0, "way_5c_ptr0");
        refill(5'd5, 7'h78, 1'b1, "way_5d_ptr1");
        read(5'd5);
        check("rd5_tag2",  32'(tag_of_set_o), 32'({7'h78, 7'h56}));
        // Pointer wrapped back to 0; look at the victim without firing
        refill_valid_i = 1'b1; refill_setid_i = 5'd5;
        #1;
        check("way_5_wrap", 32'(refill_wayid_o), 32'h0);
        refill_valid_i = 1'b0;
        tick();
        // Hold: no read request, outputs keep set 5
        check("hold_tag", 32'(tag_of_set_o), 32'({7'h78, 7'h56}));

        // Sets 0 and 31 then flush
        refill(5'd0,  7'h11, 1'b0, "way_0");
        refill(5'd31, 7'h22, 1'b0, "way_31");
        read(5'd0);
        check("rd0_pre", 32'(way_valid_o), 32'h1);
        read(5'd31);
        check("rd31_pre", 32'(way_valid_o), 32'h1);

        invalidate_i = 1'b1;
        tick();
        invalidate_i = 1'b0;
        n = 0;
        saw_done = 1'b0;
        while (!refill_ready_o && n < 40) begin
            if (flush_done_o) saw_done = 1'b1;
            n++;
            invalidate_i = (n == 5);
            tick();
        end
        invalidate_i = 1'b0;
        check("flush_len",   32'(n), 32'd32);
        check("flush_early", 32'(saw_done), 32'h0);
        check("flush_done",  32'(flush_done_o), 32'h1);
        check("flush_busy",  32'(flush_busy_o), 32'h0);
        tick();
        check("done_pulse",  32'(flush_done_o), 32'h0);

        read(5'd0);
        check("rd0_post",  32'(way_valid_o), 32'h0);
        read(5'd31);
        check("rd31_post", 32'(way_valid_o), 32'h0);
        read(5'd5);
        check("rd5_post_valid", 32'(way_valid_o), 32'h0);
        check("rd5_post_tag",   32'(tag_of_set_o), 32'({7'h78, 7'h56}));

        // Same-cycle refill and read of set 7
        r_req_valid_i = 1'b1; r_req_setid_i = 5'd7;
        refill(5'd7, 7'h3c, 1'b0, "way_7");
        r_req_valid_i = 1'b0;
`ifdef ICACHE_REFILL_BYPASS_EN
        check("rw7_valid", 32'(way_valid_o), 32'h1);
        check("rw7_tag",   32'(tag_of_set_o), 32'({7'h00, 7'h3c}));
`else
        check("rw7_valid", 32'(way_valid_o), 32'h0);
        check("rw7_tag",   32'(tag_of_set_o), 32'h0);
`endif
        read(5'd7);
        check("rd7_valid", 32'(way_valid_o), 32'h1);
        check("rd7_tag",   32'(tag_of_set_o), 32'({7'h00, 7'h3c}));

        // Set 12 full with ptr=1 before the aborted flush
        refill(5'd12, 7'h01, 1'b0, "way_12a");
        refill(5'd12, 7'h02, 1'b1, "way_12b");
        refill(5'd12, 7'h03, 1'b0, "way_12c");

        // Refill and invalidate in the same IDLE cycle
        invalidate_i = 1'b1;
        refill(5'd9, 7'h05, 1'b0, "way_9");
        invalidate_i = 1'b0;
        check("inv_busy", 32'(flush_busy_o), 32'h1);
        check("inv_ready", 32'(refill_ready_o), 32'h0);

        // Abort at flush cycle 10
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy",  32'(flush_busy_o), 32'h0);
        check("abort_ready", 32'(refill_ready_o), 32'h1);
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (flush_done_o) saw_done = 1'b1;
            tick();
        end
        check("abort_nodone", 32'(saw_done), 32'h0);
        read(5'd9);
        check("abort_rd9", 32'(way_valid_o), 32'h0);
        read(5'd7);
        check("abort_rd7_valid", 32'(way_valid_o), 32'h0);
        check("abort_rd7_tag",   32'(tag_of_set_o), 32'h0);
        refill(5'd12, 7'h0a, 1'b0, "abort_12a");
        refill(5'd12, 7'h0b, 1'b1, "abort_12b");
        refill_valid_i = 1'b1; refill_setid_i = 5'd12;
        #1;
        check("abort_ptr12", 32'(refill_wayid_o), 32'h0);
        refill_valid_i = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
